// File: rtl/vga_pkg.sv
// Default VGA 640x480@60 timing constants, counter width and the reset state of
// the registered sync outputs shared by the timing generator and its delay line.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  // Full period (H_TOTAL or V_TOTAL) from the four segment widths.
  function automatic int unsigned timing_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with synchronous active-high reset to a supplied
// value; aligns sync/blank outputs with a pipelined pixel path.
module sync_delay #(
  parameter int unsigned             DEPTH   = 2,
  parameter int unsigned             WIDTH   = 1,
  parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: every stage is reset, unlike a RAM; a stale stage would emit a bogus
  // sync pulse for up to DEPTH clocks after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) stage_q[i] <= RST_VAL;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-enable at clk/2, DrawX/DrawY counters, registered
// HS/VS/BLANK_N and line/frame strobes. Define VGA_SYNC_DELAY_EN to delay
// HS/VS/BLANK_N by 2 more clk to match a two-stage pixel ROM pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             frame_pulse,
  output logic             line_pulse
);

  localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             pix_ce_q, pix_ce_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             line_pulse_q, line_pulse_d;
  logic             frame_pulse_q, frame_pulse_d;
  sync_t            sync_q, sync_d;
  sync_t            sync_out;
  logic             line_wrap;

  always_comb begin
    pix_ce_d  = ~pix_ce_q;
    x_d       = x_q;
    y_d       = y_q;
    line_wrap = pix_ce_q && (x_q == H_MAX);

    // Compare against the max value before adding so no count ever reaches TOTAL.
    if (pix_ce_q) begin
      if (x_q == H_MAX) begin
        x_d = '0;
        y_d = (y_q == V_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    line_pulse_d  = line_wrap;
    frame_pulse_d = line_wrap && (y_d == V_VIS);

    sync_d.hs      = !((x_q >= HS_START) && (x_q < HS_END));
    sync_d.vs      = !((y_q >= VS_START) && (y_q < VS_END));
    sync_d.blank_n = (x_q < H_VIS) && (y_q < V_VIS);
  end

  // NOTE: state is only ever written with <= here; next-state values come from
  // the always_comb above so every flop sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (Reset) begin
      pix_ce_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_pulse_q  <= 1'b0;
      frame_pulse_q <= 1'b0;
      sync_q        <= SYNC_RESET;
    end else begin
      pix_ce_q      <= pix_ce_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_pulse_q  <= line_pulse_d;
      frame_pulse_q <= frame_pulse_d;
      sync_q        <= sync_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  sync_delay #(
    .DEPTH  (2),
    .WIDTH  ($bits(sync_t)),
    .RST_VAL(SYNC_RESET)
  ) u_sync_delay (
    .clk (clk),
    .rst (Reset),
    .din (sync_q),
    .dout(sync_out)
  );
`else
  assign sync_out = sync_q;
`endif

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign VGA_CLK     = pix_ce_q;
  assign VGA_HS      = sync_out.hs;
  assign VGA_VS      = sync_out.vs;
  assign VGA_BLANK_N = sync_out.blank_n;
  assign line_pulse  = line_pulse_q;
  assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen on a reduced timing; outputs are
// predicted from the clock count since reset by plain arithmetic.
module tb_vga_timing_gen;

  localparam int T_HV = 16, T_HF = 4, T_HS = 6, T_HB = 6;
  localparam int T_VV = 12, T_VF = 2, T_VS = 2, T_VB = 3;
  localparam int HT = T_HV + T_HF + T_HS + T_HB;
  localparam int VT = T_VV + T_VF + T_VS + T_VB;
  localparam int NCYC = 6000;
  localparam int RST_MID = 2000;
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, frame_pulse, line_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vga_timing_gen #(
    .H_VISIBLE(T_HV), .H_FRONT(T_HF), .H_SYNC(T_HS), .H_BACK(T_HB),
    .V_VISIBLE(T_VV), .V_FRONT(T_VF), .V_SYNC(T_VS), .V_BACK(T_VB)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .VGA_CLK    (VGA_CLK),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .frame_pulse(frame_pulse),
    .line_pulse (line_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pixel position after k clk edges since the reset edge: one pixel per 2 clk.
  function automatic void pos_at(input int k, output int x, output int y);
    int p;
    p = k / 2;
    x = p % HT;
    y = (p / HT) % VT;
  endfunction

  initial begin
    int  k = 0;
    int  last_fp = -1;
    bit  rst_now;
    int  ex, ey, sx, sy, m;
    int  e_hs, e_vs, e_bn, e_lp, e_fp;

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      rst_now = (c < 3) || (c == RST_MID) ||
                ((c > 3000) && ($urandom_range(0, 399) == 0));
      Reset = rst_now;
      @(posedge clk);
      k = rst_now ? 0 : k + 1;
      #1;

      pos_at(k, ex, ey);
      e_lp = (k > 0 && k % 2 == 0 && ex == 0) ? 1 : 0;
      e_fp = (e_lp == 1 && ey == T_VV) ? 1 : 0;

      // Sync outputs reflect the counters one clk (plus the delay line) earlier.
      m = k - 1 - DLY;
      if (m < 0) begin
        e_hs = 1; e_vs = 1; e_bn = 0;
      end else begin
        pos_at(m, sx, sy);
        e_hs = (sx >= T_HV + T_HF && sx < T_HV + T_HF + T_HS) ? 0 : 1;
        e_vs = (sy >= T_VV + T_VF && sy < T_VV + T_VF + T_VS) ? 0 : 1;
        e_bn = (sx < T_HV && sy < T_VV) ? 1 : 0;
      end

      check("draw_x",      int'(DrawX),       ex);
      check("draw_y",      int'(DrawY),       ey);
      check("vga_clk",     int'(VGA_CLK),     k % 2);
      check("vga_hs",      int'(VGA_HS),      e_hs);
      check("vga_vs",      int'(VGA_VS),      e_vs);
      check("vga_blank_n", int'(VGA_BLANK_N), e_bn);
      check("line_pulse",  int'(line_pulse),  e_lp);
      check("frame_pulse", int'(frame_pulse), e_fp);

      if (rst_now) begin
        last_fp = -1;
      end else if (frame_pulse === 1'b1) begin
        if (last_fp >= 0) check("frame_gap", c - last_fp, 2 * HT * VT);
        last_fp = c;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48: horizontal porch and sync widths in pixels.
REQ-003 The block SHALL have parameter V_VISIBLE, default 480; V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33: vertical widths in lines.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1: system clock, 50 MHz.
REQ-006 Reset  input  1: synchronous, active-high reset.
REQ-007 DrawX  output  10: current pixel column, range 0..H_TOTAL-1.
REQ-008 DrawY  output  10: current line, range 0..V_TOTAL-1.
REQ-009 VGA_CLK  output  1: pixel clock, clk/2.
REQ-010 VGA_HS  output  1: horizontal sync, active low.
REQ-011 VGA_VS  output  1: vertical sync, active low.
REQ-012 VGA_BLANK_N  output  1: high when DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-013 frame_pulse  output  1: one-clk strobe at the start of vertical blank.
REQ-014 line_pulse  output  1: one-clk strobe at the start of each line.

Function
REQ-015 The block SHALL define H_TOTAL as the sum of the four H widths (800) and V_TOTAL as the sum of the four V widths (525).
REQ-016 An internal pixel-enable (pix_ce) SHALL toggle every clk; VGA_CLK SHALL equal pix_ce.
REQ-017 DrawX SHALL increment only on clk edges where pix_ce=1, wrapping from H_TOTAL-1 to 0.
REQ-018 DrawY SHALL increment only on the same edge where DrawX wraps, wrapping from V_TOTAL-1 to 0.
REQ-019 DrawX and DrawY SHALL each hold for exactly 2 clk per pixel.
REQ-020 VGA_HS SHALL be 0 for H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
REQ-021 VGA_VS SHALL be 0 for V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
REQ-022 HS, VS and BLANK_N SHALL be registered outputs decoded from the counter values.
REQ-023 line_pulse SHALL be 1 for exactly one clk, in the cycle after DrawX becomes 0.
REQ-024 frame_pulse SHALL be 1 for exactly one clk, in the cycle after (DrawX,DrawY) becomes (0,V_VISIBLE).
REQ-025 Counter arithmetic SHALL be 10-bit unsigned and SHALL never produce values at or above H_TOTAL or V_TOTAL.

Reset
REQ-026 While Reset=1 at a clk edge: DrawX=0, DrawY=0, pix_ce=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_pulse=0, line_pulse=0, and all delay stages cleared to these values.
REQ-027 Reset asserted mid-frame SHALL take effect on the next clk edge and override all counter activity.
REQ-028 After Reset is released, the first DrawX increment SHALL occur on the second clk edge.

Configuration
REQ-029 The macro VGA_SYNC_DELAY_EN SHALL control sync alignment.
REQ-030 With VGA_SYNC_DELAY_EN defined, VGA_HS, VGA_VS and VGA_BLANK_N SHALL be delayed by a further 2 clk, matching the two-stage pointer/palette ROM latency of the pixel path.
REQ-031 Without VGA_SYNC_DELAY_EN, those outputs SHALL have the 1-clk registered latency of REQ-022 only.
REQ-032 DrawX, DrawY, frame_pulse and line_pulse SHALL be unaffected by VGA_SYNC_DELAY_EN.

Structure
REQ-033 Package vga_pkg SHALL hold the default timing constants and an H_TOTAL/V_TOTAL helper.
REQ-034 The delay stages SHALL live in sub-module sync_delay (parameterised depth and width, synchronous reset to a supplied reset value).

Verification
REQ-035 Scenario: release Reset, run one full frame -> 800*525*2 = 840000 clk between successive frame_pulse strobes.
REQ-036 Scenario: sample at DrawY=0 -> HS low for exactly 96 pixels (192 clk) starting at DrawX=656; BLANK_N high for DrawX 0..639 only.
REQ-037 Scenario: sample around DrawY=490 -> VS low only on lines 490 and 491; BLANK_N low for all of lines 480..524.
REQ-038 Scenario: sample the cycle after DrawX=799,DrawY=524 -> DrawX=0, DrawY=0, line_pulse=1, frame_pulse=0.
REQ-039 Scenario: assert Reset for 1 clk at DrawX=300,DrawY=200 -> next cycle DrawX=0, DrawY=0, HS=1, VS=1, BLANK_N=0.
REQ-040 Scenario: build with and without VGA_SYNC_DELAY_EN -> HS falling edge lands exactly 2 clk later with the macro defined; DrawX timing is identical in both builds.
